// File: rtl/sha_pad_pkg.sv
// ---------------------------------------------------------------------------
// sha_pad_pkg
// Shared definitions for the streaming SHA message padder.
//   pad_state_e : padder FSM states
//   BLK_WORDS   : words per SHA block (16 for every supported word width)
//   IDX_W       : width of the word index within a block
//   LEN_IDX_HI  : block index carrying the upper half of the bit length
//   LEN_IDX_LO  : block index carrying the lower half of the bit length
//   NBYTES_W    : width of a valid-byte count (holds 0..8)
//   lead_ones() : number of leading 1s in a keep vector, MSB first
// ---------------------------------------------------------------------------
package sha_pad_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      PAD_ONE,
      PAD_ZERO,
      LEN_HI,
      LEN_LO
   } pad_state_e;

   localparam int BLK_WORDS = 16;
   localparam int IDX_W     = $clog2(BLK_WORDS);
   localparam int NBYTES_W  = 4;

   localparam logic [IDX_W-1:0] LEN_IDX_HI = 4'd14;
   localparam logic [IDX_W-1:0] LEN_IDX_LO = 4'd15;

   // Counts the unbroken run of 1s starting at bit keepW-1 of keep.
   // Anything after the first 0 is treated as not part of the message,
   // so a ragged keep such as 1010 still means one valid byte.
   function automatic logic [NBYTES_W-1:0] lead_ones(input logic [7:0] keep,
                                                     input int         keepW);
      logic [NBYTES_W-1:0] cnt;
      logic                run;
      cnt = '0;
      run = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         if (i < keepW) begin
            if (run && keep[i]) begin
               cnt = cnt + 4'd1;
            end else begin
               run = 1'b0;
            end
         end
      end
      return cnt;
   endfunction

endpackage

// File: rtl/sha_pad_byte_insert.sv
// ---------------------------------------------------------------------------
// sha_pad_byte_insert
// Purely combinational helper that builds the tail word of a message:
// the first nbytes bytes (big-endian, MSB first) are passed through, the
// byte right after them becomes the 0x80 marker, and every later byte is
// forced to zero. With nbytes equal to the full word the data passes
// through unchanged and no marker is inserted.
// Ports:
//   data_i   : raw last beat of the message
//   nbytes_i : number of valid leading bytes (0..WORD_W/8)
//   data_o   : masked word with marker
// ---------------------------------------------------------------------------
module sha_pad_byte_insert
   import sha_pad_pkg::*;
#(
   parameter  int WORD_W = 32,
   localparam int KEEP_W = WORD_W / 8
) (
   input  logic [WORD_W-1:0]   data_i,
   input  logic [NBYTES_W-1:0] nbytes_i,
   output logic [WORD_W-1:0]   data_o
);

   // Walk the byte lanes from the most significant one down. Lanes before
   // the count keep their data, the lane at the count gets the marker and
   // the rest stay at the zero default, which also wipes any junk the
   // upstream left in unused lanes.
   always_comb begin
      data_o = '0;
      for (int b = 0; b < KEEP_W; b++) begin
         if (b < int'(nbytes_i)) begin
            data_o[WORD_W-1-8*b -: 8] = data_i[WORD_W-1-8*b -: 8];
         end else if (b == int'(nbytes_i)) begin
            data_o[WORD_W-1-8*b -: 8] = 8'h80;
         end
      end
   end

endmodule

// File: rtl/sha_msg_padder.sv
// ---------------------------------------------------------------------------
// sha_msg_padder
// Streaming FIPS 180-4 message padder. Takes a byte-granular message as a
// stream of big-endian words and produces complete 16-word blocks: message
// data, the 0x80 marker, zero fill and the two-word bit length. WORD_W=32
// serves SHA-1/SHA-256, WORD_W=64 serves SHA-512.
//
// Optional feature macro: SHA_PAD_LEN_BASE_EN
//   defined   : len_base port exists and seeds the bit count of each
//               message (for HMAC, where a key block precedes the stream)
//   undefined : no len_base port, every message counts from zero
//
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   s_data     : input message word, first byte in the MSBs
//   s_keep     : valid bytes of the last beat, MSB first
//   s_valid    : input word valid
//   s_last     : final beat of the message
//   s_ready    : padder can take an input word this cycle
//   m_data     : padded block word
//   m_valid    : output word valid
//   m_ready    : hash core takes the output word
//   m_first    : word 0 of block 0 of a message
//   m_blk_end  : word 15 of every block
//   m_msg_end  : final length word of the message
//   busy       : message in flight or output word pending
//   len_base   : (macro only) starting bit count, sampled on first beat
// ---------------------------------------------------------------------------
module sha_msg_padder
   import sha_pad_pkg::*;
#(
   parameter  int WORD_W = 32,
   localparam int KEEP_W = WORD_W / 8,
   localparam int LEN_W  = 2 * WORD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] s_data,
   input  logic [KEEP_W-1:0] s_keep,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   output logic [WORD_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_first,
   output logic              m_blk_end,
   output logic              m_msg_end,
   output logic              busy
`ifdef SHA_PAD_LEN_BASE_EN
   ,
   input  logic [LEN_W-1:0]  len_base
`endif
);

   localparam logic [WORD_W-1:0] MARKER_WORD = {8'h80, {(WORD_W-8){1'b0}}};

   pad_state_e          state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [LEN_W-1:0]    bitlen_q, bitlen_d;

   logic [WORD_W-1:0]   outData_q;
   logic                outValid_q;
   logic                outFirst_q;
   logic                outBlkEnd_q;
   logic                outMsgEnd_q;

   logic                advance;
   logic                inAccept;
   logic [NBYTES_W-1:0] nbytes;
   logic [WORD_W-1:0]   tailWord;
   logic [LEN_W-1:0]    beatBits;
   logic [LEN_W-1:0]    lenStart;
   pad_state_e          afterMarker;

   logic                emit;
   logic [WORD_W-1:0]   emitData;
   logic                emitFirst;
   logic                emitMsgEnd;

`ifdef SHA_PAD_LEN_BASE_EN
   assign lenStart = len_base;
`else
   assign lenStart = '0;
`endif

   // The output stage may load a new word whenever it is empty or the
   // core is taking the current one. Every state transition is tied to a
   // word being loaded, so a stalled core freezes the whole padder.
   assign advance  = !outValid_q || m_ready;
   assign s_ready  = !rst && ((state_q == IDLE) || (state_q == DATA)) && advance;
   assign inAccept = s_valid && s_ready;

   assign nbytes   = lead_ones(8'(s_keep), KEEP_W);
   assign beatBits = s_last ? LEN_W'({nbytes, 3'b000}) : LEN_W'(WORD_W);

   // Once the marker has gone out, the zero run has to end right before
   // the length slot. A marker at index 13 leaves no room for zeros, so it
   // jumps straight to the length; anything later spills into a fresh
   // block whose zero run ends at index 13 in the same way.
   assign afterMarker = (idx_q == LEN_IDX_HI - 4'd1) ? LEN_HI : PAD_ZERO;

   sha_pad_byte_insert #(
      .WORD_W(WORD_W)
   ) u_insert (
      .data_i  (s_data),
      .nbytes_i(nbytes),
      .data_o  (tailWord)
   );

   // Next-state and word selection. Input beats are only accepted in IDLE
   // and DATA; the pad and length states generate their own words whenever
   // the output stage has room. A last beat that fills the whole word goes
   // out untouched and the marker follows as its own word from PAD_ONE.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      bitlen_d   = bitlen_q;
      emit       = 1'b0;
      emitData   = '0;
      emitFirst  = 1'b0;
      emitMsgEnd = 1'b0;

      case (state_q)
         IDLE: begin
            if (inAccept) begin
               emit      = 1'b1;
               emitFirst = 1'b1;
               bitlen_d  = lenStart + beatBits;
               if (s_last) begin
                  emitData = tailWord;
                  state_d  = (nbytes == NBYTES_W'(KEEP_W)) ? PAD_ONE : afterMarker;
               end else begin
                  emitData = s_data;
                  state_d  = DATA;
               end
            end
         end
         DATA: begin
            if (inAccept) begin
               emit     = 1'b1;
               bitlen_d = bitlen_q + beatBits;
               if (s_last) begin
                  emitData = tailWord;
                  state_d  = (nbytes == NBYTES_W'(KEEP_W)) ? PAD_ONE : afterMarker;
               end else begin
                  emitData = s_data;
               end
            end
         end
         PAD_ONE: begin
            if (advance) begin
               emit     = 1'b1;
               emitData = MARKER_WORD;
               state_d  = afterMarker;
            end
         end
         PAD_ZERO: begin
            if (advance) begin
               emit = 1'b1;
               if (idx_q == LEN_IDX_HI - 4'd1) begin
                  state_d = LEN_HI;
               end
            end
         end
         LEN_HI: begin
            if (advance) begin
               emit     = 1'b1;
               emitData = bitlen_q[LEN_W-1:WORD_W];
               state_d  = LEN_LO;
            end
         end
         LEN_LO: begin
            if (advance) begin
               emit       = 1'b1;
               emitData   = bitlen_q[WORD_W-1:0];
               emitMsgEnd = 1'b1;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (emit) begin
         idx_d = idx_q + 4'd1;
      end
   end

   // FSM, block index and length accumulator. Reset drops any partial
   // message so nothing more is emitted for it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         bitlen_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         bitlen_q <= bitlen_d;
      end
   end

   // Single output register. It only changes when it may hand over, so
   // data and flags sit still for as long as the core holds m_ready low.
   // The block-end flag comes from the index of the word being loaded.
   always_ff @(posedge clk) begin
      if (rst) begin
         outData_q   <= '0;
         outValid_q  <= 1'b0;
         outFirst_q  <= 1'b0;
         outBlkEnd_q <= 1'b0;
         outMsgEnd_q <= 1'b0;
      end else if (advance) begin
         outValid_q  <= emit;
         outFirst_q  <= emit && emitFirst;
         outBlkEnd_q <= emit && (idx_q == LEN_IDX_LO);
         outMsgEnd_q <= emit && emitMsgEnd;
         if (emit) begin
            outData_q <= emitData;
         end
      end
   end

   assign m_data    = outData_q;
   assign m_valid   = outValid_q;
   assign m_first   = outFirst_q;
   assign m_blk_end = outBlkEnd_q;
   assign m_msg_end = outMsgEnd_q;
   assign busy      = (state_q != IDLE) || outValid_q;

endmodule

// File: tb/tb_sha_msg_padder.sv
// ---------------------------------------------------------------------------
// tb_sha_msg_padder
// Bench for sha_msg_padder: a 32-bit instance exercised with a table of
// single-beat tails, hand sequences for the multi-block and reset cases,
// and random messages compared against a byte-level padding model; a
// 64-bit instance gets the "abc" message. Honours SHA_PAD_LEN_BASE_EN.
// ---------------------------------------------------------------------------
module tb_sha_msg_padder;

   typedef logic [7:0] byte_q[$];

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } beat_t;
   typedef beat_t beat_q[$];

   typedef struct {
      logic [31:0] data;
      logic        first;
      logic        blkEnd;
      logic        msgEnd;
   } word_t;
   typedef word_t word_q[$];

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic [31:0] expW0;
      logic [31:0] expW1;
      logic [31:0] expLen;
   } vec_t;

`ifdef SHA_PAD_LEN_BASE_EN
   localparam logic [63:0] BASE = 64'd512;
`else
   localparam logic [63:0] BASE = 64'd0;
`endif

   logic        clk;
   logic        rst;
   logic [31:0] s_data;
   logic [3:0]  s_keep;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_first;
   logic        m_blk_end;
   logic        m_msg_end;
   logic        busy;

   logic [63:0] s_data64;
   logic [7:0]  s_keep64;
   logic        s_valid64;
   logic        s_last64;
   logic        s_ready64;
   logic [63:0] m_data64;
   logic        m_valid64;
   logic        m_ready64;
   logic        m_first64;
   logic        m_blk_end64;
   logic        m_msg_end64;
   logic        busy64;

`ifdef SHA_PAD_LEN_BASE_EN
   logic [63:0]  lenBase32;
   logic [127:0] lenBase64;
   assign lenBase32 = BASE;
   assign lenBase64 = '0;
`endif

   int    checks;
   int    errors;
   int    stallPct;
   word_q captured;

   sha_msg_padder #(.WORD_W(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .s_data   (s_data),
      .s_keep   (s_keep),
      .s_valid  (s_valid),
      .s_last   (s_last),
      .s_ready  (s_ready),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_first  (m_first),
      .m_blk_end(m_blk_end),
      .m_msg_end(m_msg_end),
      .busy     (busy)
`ifdef SHA_PAD_LEN_BASE_EN
      ,
      .len_base (lenBase32)
`endif
   );

   sha_msg_padder #(.WORD_W(64)) dut64 (
      .clk      (clk),
      .rst      (rst),
      .s_data   (s_data64),
      .s_keep   (s_keep64),
      .s_valid  (s_valid64),
      .s_last   (s_last64),
      .s_ready  (s_ready64),
      .m_data   (m_data64),
      .m_valid  (m_valid64),
      .m_ready  (m_ready64),
      .m_first  (m_first64),
      .m_blk_end(m_blk_end64),
      .m_msg_end(m_msg_end64),
      .busy     (busy64)
`ifdef SHA_PAD_LEN_BASE_EN
      ,
      .len_base (lenBase64)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Output side of the 32-bit instance: random backpressure, capture of
   // every handed-over word, and a hold check on every stalled cycle.
   initial begin : monitor
      logic        prevStall;
      logic [34:0] held;
      prevStall = 1'b0;
      held      = '0;
      m_ready   = 1'b0;
      forever begin
         @(negedge clk);
         m_ready = ($urandom_range(99) >= stallPct);
         #1;
         if (rst) begin
            prevStall = 1'b0;
         end else begin
            if (prevStall) begin
               checkOutput("stall_hold", {m_data, m_first, m_blk_end, m_msg_end}, held);
            end
            if (m_valid && m_ready) begin
               captured.push_back('{m_data, m_first, m_blk_end, m_msg_end});
            end
            prevStall = m_valid && !m_ready;
            held      = {m_data, m_first, m_blk_end, m_msg_end};
         end
      end
   end

   // Presents one beat and holds it until the padder takes it.
   task automatic applyStimulus(input beat_t b);
      int cyc;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = b.data;
      s_keep  = b.keep;
      s_last  = b.last;
      #2;
      cyc = 0;
      while (!s_ready && cyc < 1000) begin
         @(negedge clk);
         #2;
         cyc++;
      end
      if (!s_ready) begin
         checkOutput("beat_accept_timeout", 128'd0, 128'd1);
      end
   endtask

   task automatic releaseInputs();
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic sendBeats(input beat_q bq, input int count);
      for (int i = 0; i < count; i++) begin
         applyStimulus(bq[i]);
      end
      releaseInputs();
   endtask

   task automatic waitWords(input int n, input string name);
      int cyc;
      cyc = 0;
      while (captured.size() < n && cyc < 4000) begin
         @(negedge clk);
         cyc++;
      end
      repeat (8) @(negedge clk);
      checkOutput({name, "_count"}, captured.size(), n);
   endtask

   // Splits a byte message into beats. Unused lanes carry random junk and
   // the last keep has random bits after its first zero.
   function automatic beat_q buildBeats(input byte_q msg);
      beat_q q;
      beat_t bt;
      int    n;
      int    nb;
      int    rem;
      n  = msg.size();
      nb = (n == 0) ? 1 : (n + 3) / 4;
      for (int k = 0; k < nb; k++) begin
         bt.last = (k == nb - 1);
         bt.data = $urandom();
         bt.keep = 4'($urandom());
         rem     = n - 4 * k;
         for (int j = 0; j < 4; j++) begin
            if (j < rem) begin
               bt.data[31-8*j -: 8] = msg[4*k+j];
            end
            if (bt.last) begin
               if (j < rem) begin
                  bt.keep[3-j] = 1'b1;
               end else if (j == rem) begin
                  bt.keep[3-j] = 1'b0;
               end
            end
         end
         q.push_back(bt);
      end
      return q;
   endfunction

   // Reference: plain FIPS 180-4 padding of a byte string, then cut into
   // 32-bit words with the block and message flags derived from position.
   function automatic word_q model(input byte_q msg);
      byte_q       b;
      logic [63:0] bits;
      word_q       w;
      word_t       x;
      int          nw;
      b    = msg;
      bits = BASE + 64'(msg.size()) * 64'd8;
      b.push_back(8'h80);
      while (b.size() % 64 != 56) begin
         b.push_back(8'h00);
      end
      for (int i = 7; i >= 0; i--) begin
         b.push_back(bits[8*i +: 8]);
      end
      nw = b.size() / 4;
      for (int i = 0; i < nw; i++) begin
         x.data   = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
         x.first  = (i == 0);
         x.blkEnd = (i % 16 == 15);
         x.msgEnd = (i == nw - 1);
         w.push_back(x);
      end
      return w;
   endfunction

   task automatic runMessage(input byte_q msg, input string name);
      beat_q bq;
      word_q exp;
      int    n;
      bq  = buildBeats(msg);
      exp = model(msg);
      captured.delete();
      sendBeats(bq, bq.size());
      waitWords(exp.size(), name);
      n = (captured.size() < exp.size()) ? captured.size() : exp.size();
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("%s_w%0d", name, i),
                     {captured[i].data, captured[i].first, captured[i].blkEnd, captured[i].msgEnd},
                     {exp[i].data, exp[i].first, exp[i].blkEnd, exp[i].msgEnd});
      end
   endtask

   // "abc" as a single beat, checked against fixed words; also checks that
   // a beat offered while padding is refused.
   task automatic runAbc(input string name);
      logic [31:0] expData;
      captured.delete();
      applyStimulus('{32'h61626300, 4'b1110, 1'b1});
      @(negedge clk);
      s_data = 32'hFFFF_FFFF;
      #2;
      checkOutput({name, "_pad_s_ready"}, s_ready, 1'b0);
      checkOutput({name, "_pad_busy"}, busy, 1'b1);
      s_valid = 1'b0;
      s_last  = 1'b0;
      waitWords(16, name);
      if (captured.size() >= 16) begin
         for (int i = 0; i < 16; i++) begin
            expData = (i == 0) ? 32'h61626380 : (i == 15) ? (BASE[31:0] + 32'd24) : 32'h0;
            checkOutput($sformatf("%s_w%0d", name, i),
                        {captured[i].data, captured[i].first, captured[i].blkEnd, captured[i].msgEnd},
                        {expData, (i == 0), (i == 15), (i == 15)});
         end
      end
   endtask

   task automatic runAbc64();
      int          cyc;
      logic [66:0] got[$];
      logic [63:0] expData;
      @(negedge clk);
      s_valid64 = 1'b1;
      s_data64  = 64'h6162_6300_0000_0000;
      s_keep64  = 8'hE0;
      s_last64  = 1'b1;
      #2;
      cyc = 0;
      while (!s_ready64 && cyc < 100) begin
         @(negedge clk);
         #2;
         cyc++;
      end
      checkOutput("w64_accept", s_ready64, 1'b1);
      @(negedge clk);
      s_valid64 = 1'b0;
      s_last64  = 1'b0;
      repeat (40) begin
         #1;
         if (m_valid64) begin
            got.push_back({m_data64, m_first64, m_blk_end64, m_msg_end64});
         end
         @(negedge clk);
      end
      checkOutput("w64_count", got.size(), 16);
      if (got.size() >= 16) begin
         for (int i = 0; i < 16; i++) begin
            expData = (i == 0) ? 64'h6162_6380_0000_0000 : (i == 15) ? 64'h18 : 64'h0;
            checkOutput($sformatf("w64_w%0d", i), got[i], {expData, (i == 0), (i == 15), (i == 15)});
         end
      end
   endtask

   initial begin : main
      vec_t  vecs[7];
      byte_q msg;
      beat_q bq;

      vecs[0] = '{32'hDEADBEEF, 4'b0000, 32'h80000000, 32'h00000000, 32'd0};
      vecs[1] = '{32'hDEADBEEF, 4'b1000, 32'hDE800000, 32'h00000000, 32'd8};
      vecs[2] = '{32'hDEADBEEF, 4'b1100, 32'hDEAD8000, 32'h00000000, 32'd16};
      vecs[3] = '{32'hDEADBEEF, 4'b1110, 32'hDEADBE80, 32'h00000000, 32'd24};
      vecs[4] = '{32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h80000000, 32'd32};
      vecs[5] = '{32'hDEADBEEF, 4'b1010, 32'hDE800000, 32'h00000000, 32'd8};
      vecs[6] = '{32'hDEADBEEF, 4'b0111, 32'h80000000, 32'h00000000, 32'd0};

      checks    = 0;
      errors    = 0;
      stallPct  = 0;
      rst       = 1'b1;
      s_valid   = 1'b0;
      s_data    = '0;
      s_keep    = '0;
      s_last    = 1'b0;
      s_valid64 = 1'b0;
      s_data64  = '0;
      s_keep64  = '0;
      s_last64  = 1'b0;
      m_ready64 = 1'b1;

      repeat (3) @(negedge clk);
      #2;
      checkOutput("rst_m_valid", m_valid, 1'b0);
      checkOutput("rst_flags", {m_first, m_blk_end, m_msg_end}, 3'b000);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_s_ready", s_ready, 1'b0);
      checkOutput("rst_m_data", m_data, 32'h0);
      checkOutput("rst64_state", {m_valid64, busy64, s_ready64}, 3'b000);
      @(negedge clk);
      rst = 1'b0;

      runAbc("abc");

      for (int v = 0; v < 7; v++) begin
         captured.delete();
         applyStimulus('{vecs[v].data, vecs[v].keep, 1'b1});
         releaseInputs();
         waitWords(16, $sformatf("vec%0d", v));
         if (captured.size() >= 16) begin
            checkOutput($sformatf("vec%0d_w0", v), {captured[0].data, captured[0].first},
                        {vecs[v].expW0, 1'b1});
            checkOutput($sformatf("vec%0d_w1", v), captured[1].data, vecs[v].expW1);
            checkOutput($sformatf("vec%0d_w15", v), {captured[15].data, captured[15].msgEnd},
                        {vecs[v].expLen + BASE[31:0], 1'b1});
         end
      end

      msg.delete();
      runMessage(msg, "empty");

      msg.delete();
      for (int i = 0; i < 56; i++) begin
         msg.push_back(8'($urandom()));
      end
      runMessage(msg, "full14");
      if (captured.size() >= 32) begin
         checkOutput("full14_marker", captured[14].data, 32'h80000000);
         checkOutput("full14_len", {captured[31].data, captured[31].msgEnd},
                     {BASE[31:0] + 32'h1C0, 1'b1});
      end
      stallPct = 30;
      runMessage(msg, "full14_stall");
      stallPct = 0;

      for (int r = 0; r < 12; r++) begin
         msg.delete();
         repeat ($urandom_range(140)) msg.push_back(8'($urandom()));
         stallPct = $urandom_range(50);
         runMessage(msg, $sformatf("rand%0d", r));
      end
      stallPct = 0;

      msg.delete();
      for (int i = 0; i < 40; i++) begin
         msg.push_back(8'(i + 1));
      end
      bq = buildBeats(msg);
      captured.delete();
      sendBeats(bq, 5);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #2;
      checkOutput("midrst_m_valid", m_valid, 1'b0);
      checkOutput("midrst_busy", busy, 1'b0);
      checkOutput("midrst_s_ready", s_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      captured.delete();
      repeat (20) @(negedge clk);
      checkOutput("midrst_residual", captured.size(), 0);
      checkOutput("midrst_idle", {busy, s_ready}, 2'b01);
      runAbc("abc_after_rst");

      runAbc64();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
